d_write_buffer: RTL and testbench
=================================

# d_write_buffer

Posted write buffer between the write-through data cache's memory port and main memory. Writes from the cache are acknowledged in the cycle they are presented and drained to memory in FIFO order, so the CPU does not pay memory write latency on every store. Reads (cache misses) bypass queued writes unless a queued write targets the same word, in which case the read stalls until that write has drained. The block owns the single memory port and arbitrates between read misses and write drains.

## Interface
- A_WIDTH, 32, address width
- DEPTH_LOG2, 2, log2 of FIFO entries (default 4 entries)
- clk  in  1  clock
- clrn  in  1  reset, asynchronous, active-low
- c_a  in  A_WIDTH  byte address from cache
- c_din  in  32  write data from cache
- c_wen  in  4  byte enables for writes
- c_strobe  in  1  request valid; held stable until c_ready
- c_rw  in  1  0 read, 1 write
- c_ready  out  1  request complete this cycle
- c_dout  out  32  read data to cache
- mem_a  out  A_WIDTH  memory address
- mem_din  out  32  memory write data
- mem_wen  out  4  memory byte enables
- mem_strobe  out  1  memory request
- mem_rw  out  1  0 read, 1 write
- mem_dout  in  32  memory read data
- mem_ready  in  1  memory access complete (one-cycle pulse)
- wb_empty  out  1  FIFO holds no entries

## Operation
- Entry: {addr, data, wen}. Circular FIFO: head, tail (DEPTH_LOG2 bits, wrap modulo depth), count (DEPTH_LOG2+1 bits). full = count==depth; wb_empty = count==0.
- Write accept: c_strobe & c_rw & ~full -> c_ready=1 combinationally; entry written at tail on that edge, tail+1. Every such cycle is one distinct write. Full -> c_ready=0; no back-pressure bypass while an entry pops in the same cycle.
- Hazard: c_strobe & ~c_rw & any valid entry with addr[A_WIDTH-1:2] == c_a[A_WIDTH-1:2] (all DEPTH entries compared).
- FSM states IDLE, WR, RD:
  - IDLE: read request without hazard -> RD; else if ~wb_empty -> WR; else stay. Read has priority over drain.
  - WR: mem_strobe=1, mem_rw=1, mem_a/mem_din/mem_wen = head entry. On mem_ready: pop (head+1), -> IDLE.
  - RD: mem_strobe=1, mem_rw=0, mem_a=c_a, mem_wen=0. c_ready=mem_ready, c_dout=mem_dout (pass-through). On mem_ready -> IDLE.
- Push and pop in the same cycle: count unchanged, head and tail both advance.
- Outside WR: mem_din/mem_a show head entry (mem_a=c_a in RD), mem_wen=0; mem_strobe=0 in IDLE.
- c_dout = mem_dout always; valid only when c_ready with c_rw=0.

## Timing
- Reset (async, immediate): state IDLE, head=tail=count=0, all FIFO valid cleared; mem_strobe=0, mem_rw=0, mem_wen=0, mem_a=0, mem_din=0, c_ready=0, wb_empty=1.
- Reset mid-transaction: mem_strobe drops immediately; queued writes discarded.
- Write latency to CPU: 0 cycles (same-cycle c_ready) if not full.
- Drain: memory write begins the cycle after the entry becomes head and the FSM is IDLE; IDLE between consecutive accesses costs 1 cycle.
- Read miss latency: 1 cycle (IDLE->RD) + memory latency, plus completion of any in-flight WR, plus drain of hazarding entries.
- mem_ready while mem_strobe=0 is ignored.

## Test plan
- Reset: assert clrn=0 mid-WR -> mem_strobe=0 that cycle, wb_empty=1, c_ready=0, mem_wen=0.
- Single store: c_a=0x100, c_din=0xDEADBEEF, c_wen=1111 -> c_ready=1 same cycle; next cycle mem_strobe=1, mem_rw=1, mem_a=0x100; mem_ready 3 cycles later -> wb_empty=1 the cycle after.
- Full: mem_ready held 0, stores to 0x0,0x4,0x8,0xC accepted; fifth store 0x10 -> c_ready=0; one mem_ready pulse -> 0x10 accepted the next cycle; memory sees 0x0,0x4,0x8,0xC,0x10 in order.
- Hazard: store 0x200 queued, read 0x202 -> c_ready=0 until 0x200 write completes, then RD, mem_a=0x202, c_dout=mem_dout=0x12345678 with c_ready=1.
- Bypass: stores 0x300,0x304 queued, read 0x400 issued while WR(0x300) in flight -> after it completes, RD(0x400) precedes WR(0x304).
- Byte store c_a=0x103, c_wen=0001, c_din=0x000000AB -> mem_wen=0001, mem_din=0x000000AB, mem_a=0x103.

Source files
------------

// File: rtl/d_write_buffer.sv
// d_write_buffer
//   Posted write buffer between a write-through data cache and main memory.
//   Stores are acknowledged in the cycle they are presented, queued in a small
//   circular FIFO and drained to memory in order. A read miss bypasses the
//   queued stores unless one of them targets the same word. In that case the
//   read waits until that store has drained. The block owns the single memory
//   port and arbitrates between read misses and store drains.
//
// Ports
//   clk, clrn        clock, asynchronous active-low reset
//   c_a/c_din/c_wen  cache request address, write data and byte enables
//   c_strobe, c_rw   request valid (held until c_ready), 0 read / 1 write
//   c_ready, c_dout  request complete this cycle, read data (pass-through)
//   mem_*            memory port: address, write data, byte enables, strobe,
//                    direction, read data, one-cycle completion pulse
//   wb_empty         FIFO holds no entries
//
// States
//   IDLE | no memory access; pick a read miss or the next drain
//   WR   | writing the head entry to memory
//   RD   | forwarding the cache read miss to memory
module d_write_buffer #(
  parameter int A_WIDTH    = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] c_a,
  input  logic [31:0]        c_din,
  input  logic [3:0]         c_wen,
  input  logic               c_strobe,
  input  logic               c_rw,
  output logic               c_ready,
  output logic [31:0]        c_dout,
  output logic [A_WIDTH-1:0] mem_a,
  output logic [31:0]        mem_din,
  output logic [3:0]         mem_wen,
  output logic               mem_strobe,
  output logic               mem_rw,
  input  logic [31:0]        mem_dout,
  input  logic               mem_ready,
  output logic               wb_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t                state, state_nxt;
  logic [A_WIDTH-1:0]    q_addr [DEPTH];
  logic [31:0]           q_data [DEPTH];
  logic [3:0]            q_wen  [DEPTH];
  logic [DEPTH-1:0]      q_valid;
  logic [DEPTH_LOG2-1:0] head, tail;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, push, pop, rd_req, hazard;

  assign full     = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign wb_empty = (count == '0);
  assign rd_req   = c_strobe & ~c_rw;
  // Gated by clrn so that no store is acknowledged while reset is held.
  assign push     = clrn & c_strobe & c_rw & ~full;
  assign pop      = (state == WR) & mem_ready;

  // A read must not overtake a queued store to the same word.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i] && (q_addr[i][A_WIDTH-1:2] == c_a[A_WIDTH-1:2])) begin
        hazard = 1'b1;
      end
    end
    hazard = hazard & rd_req;
  end

  // Push and pop never address the same slot: push needs count < DEPTH and
  // pop needs count > 0, so tail != head whenever both fire.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      q_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
        q_wen[i]  <= '0;
      end
    end else begin
      if (push) begin
        q_addr[tail]  <= c_a;
        q_data[tail]  <= c_din;
        q_wen[tail]   <= c_wen;
        q_valid[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A store accepted while the FIFO is empty becomes head immediately, so
  // its drain starts on the next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_req && !hazard) begin
          state_nxt = RD;
        end else if (!wb_empty || push) begin
          state_nxt = WR;
        end
      end
      WR: if (mem_ready) state_nxt = IDLE;
      RD: if (mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_strobe = (state != IDLE);
    mem_rw     = (state == WR);
    mem_a      = (state == RD) ? c_a : q_addr[head];
    mem_din    = q_data[head];
    mem_wen    = (state == WR) ? q_wen[head] : 4'b0000;
    c_ready    = push | ((state == RD) & mem_ready);
    c_dout     = mem_dout;
  end

endmodule

// File: tb/tb_d_write_buffer.sv
module tb_d_write_buffer;

  logic        clk;
  logic        clrn;
  logic [31:0] c_a;
  logic [31:0] c_din;
  logic [3:0]  c_wen;
  logic        c_strobe;
  logic        c_rw;
  logic        c_ready;
  logic [31:0] c_dout;
  logic [31:0] mem_a;
  logic [31:0] mem_din;
  logic [3:0]  mem_wen;
  logic        mem_strobe;
  logic        mem_rw;
  logic [31:0] mem_dout;
  logic        mem_ready;
  logic        wb_empty;

  logic        auto_mem;
  logic        man_rdy, auto_rdy;
  logic [31:0] man_dout, auto_dout;

  assign mem_ready = auto_mem ? auto_rdy  : man_rdy;
  assign mem_dout  = auto_mem ? auto_dout : man_dout;

  d_write_buffer #(.A_WIDTH(32), .DEPTH_LOG2(2)) dut (
    .clk(clk), .clrn(clrn),
    .c_a(c_a), .c_din(c_din), .c_wen(c_wen), .c_strobe(c_strobe), .c_rw(c_rw),
    .c_ready(c_ready), .c_dout(c_dout),
    .mem_a(mem_a), .mem_din(mem_din), .mem_wen(mem_wen),
    .mem_strobe(mem_strobe), .mem_rw(mem_rw),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .wb_empty(wb_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
  } wr_t;

  int          n_assert = 0;
  int          n_fail   = 0;
  wr_t         exp_q[$];
  logic [31:0] ref_mem   [16];
  logic [31:0] mem_model [16];
  int          lat;
  logic        done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Advance to just after the next rising edge; a manual mem_ready is a one-cycle pulse.
  task automatic nxt();
    @(posedge clk);
    #1;
    man_rdy = 1'b0;
  endtask

  task automatic put_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    c_strobe = 1'b1; c_rw = 1'b1; c_a = a; c_din = d; c_wen = w;
  endtask

  task automatic put_rd(input logic [31:0] a);
    c_strobe = 1'b1; c_rw = 1'b0; c_a = a;
  endtask

  // Called just after an edge: find the next memory write, check its address, pulse ready.
  task automatic drain_one(input logic [31:0] a);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (mem_strobe && mem_rw) begin
        found = 1'b1;
        break;
      end
      nxt();
    end
    n_assert++;
    assert (found) else begin
      n_fail++;
      $error("FAIL drain_timeout: no memory write seen, expected address %h", a);
    end
    chk("drain_addr", mem_a, a);
    man_rdy = 1'b1;
    nxt();
  endtask

  // One cycle of random traffic against the behavioural memory (inputs already driven).
  task automatic rand_cycle();
    wr_t e;
    auto_rdy = 1'b0;
    if (mem_strobe) begin
      if (lat == 0) begin
        auto_rdy = 1'b1;
        if (mem_rw) begin
          n_assert++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL wr_unexpected: memory write to %h with nothing queued", mem_a);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", mem_a, e.a);
            chk("wr_data", mem_din, e.d);
            chk("wr_wen", {28'd0, mem_wen}, {28'd0, e.w});
          end
          mem_model[mem_a[5:2]] = merge(mem_model[mem_a[5:2]], mem_din, mem_wen);
        end else begin
          auto_dout = mem_model[mem_a[5:2]];
        end
        lat = $urandom_range(0, 3);
      end else begin
        lat--;
      end
    end else begin
      // stray ready pulses while the port is idle must be ignored
      auto_rdy  = ($urandom_range(0, 7) == 0);
      auto_dout = $urandom;
    end
    #1;
    if (!(mem_strobe && mem_rw)) chk("mem_wen_idle", {28'd0, mem_wen}, 32'd0);
    if (c_strobe && c_ready) begin
      if (c_rw) begin
        e.a = c_a; e.d = c_din; e.w = c_wen;
        exp_q.push_back(e);
        ref_mem[c_a[5:2]] = merge(ref_mem[c_a[5:2]], c_din, c_wen);
      end else begin
        chk("rd_data", c_dout, ref_mem[c_a[5:2]]);
      end
      done = 1'b1;
    end
    nxt();
  endtask

  initial begin
    int waited;
    auto_mem = 1'b0; man_rdy = 1'b0; auto_rdy = 1'b0;
    man_dout = 32'h0; auto_dout = 32'h0;
    c_strobe = 1'b0; c_rw = 1'b0; c_a = '0; c_din = '0; c_wen = '0;
    clrn = 1'b0;
    #1;
    chk("rst_wb_empty",   {31'd0, wb_empty},   32'd1);
    chk("rst_mem_strobe", {31'd0, mem_strobe}, 32'd0);
    chk("rst_mem_rw",     {31'd0, mem_rw},     32'd0);
    chk("rst_mem_wen",    {28'd0, mem_wen},    32'd0);
    chk("rst_mem_a",      mem_a,               32'd0);
    chk("rst_mem_din",    mem_din,             32'd0);
    chk("rst_c_ready",    {31'd0, c_ready},    32'd0);
    nxt(); nxt();
    clrn = 1'b1;
    nxt();

    // single store, memory responds 3 cycles after the write starts
    put_wr(32'h100, 32'hDEADBEEF, 4'b1111);
    #1;
    chk("st_c_ready", {31'd0, c_ready}, 32'd1);
    nxt();
    c_strobe = 1'b0;
    #1;
    chk("st_mem_strobe", {31'd0, mem_strobe}, 32'd1);
    chk("st_mem_rw",     {31'd0, mem_rw},     32'd1);
    chk("st_mem_a",      mem_a,               32'h100);
    chk("st_mem_din",    mem_din,             32'hDEADBEEF);
    chk("st_mem_wen",    {28'd0, mem_wen},    32'hF);
    chk("st_not_empty",  {31'd0, wb_empty},   32'd0);
    nxt(); nxt(); nxt();
    man_rdy = 1'b1;
    nxt();
    #1;
    chk("st_empty_after", {31'd0, wb_empty},   32'd1);
    chk("st_idle_after",  {31'd0, mem_strobe}, 32'd0);

    // byte store
    put_wr(32'h103, 32'h000000AB, 4'b0001);
    nxt();
    c_strobe = 1'b0;
    #1;
    chk("byte_mem_wen", {28'd0, mem_wen}, 32'h1);
    chk("byte_mem_din", mem_din,          32'h000000AB);
    chk("byte_mem_a",   mem_a,            32'h103);
    man_rdy = 1'b1;
    nxt();

    // fill the FIFO, fifth store waits for a pop
    for (int i = 0; i < 4; i++) begin
      put_wr(32'(4 * i), 32'hA0 + 32'(i), 4'b1111);
      #1;
      chk("full_accept", {31'd0, c_ready}, 32'd1);
      nxt();
    end
    put_wr(32'h10, 32'hA4, 4'b1111);
    #1;
    chk("full_stall", {31'd0, c_ready}, 32'd0);
    chk("full_head",  mem_a,            32'h0);
    man_rdy = 1'b1;
    #1;
    chk("full_no_bypass", {31'd0, c_ready}, 32'd0);
    nxt();
    #1;
    chk("full_accept_after_pop", {31'd0, c_ready}, 32'd1);
    nxt();
    c_strobe = 1'b0;
    drain_one(32'h4);
    drain_one(32'h8);
    drain_one(32'hC);
    drain_one(32'h10);
    #1;
    chk("full_drained", {31'd0, wb_empty}, 32'd1);
    nxt();

    // read hazard on a queued store to the same word
    put_wr(32'h200, 32'h55AA55AA, 4'b1111);
    nxt();
    put_rd(32'h202);
    #1;
    chk("hz_stall0",  {31'd0, c_ready}, 32'd0);
    chk("hz_wr_addr", mem_a,            32'h200);
    nxt();
    #1;
    chk("hz_stall1", {31'd0, c_ready}, 32'd0);
    man_rdy = 1'b1;
    #1;
    chk("hz_stall_wr_done", {31'd0, c_ready}, 32'd0);
    nxt();
    #1;
    chk("hz_idle_gap", {31'd0, mem_strobe}, 32'd0);
    nxt();
    #1;
    chk("hz_rd_strobe", {31'd0, mem_strobe}, 32'd1);
    chk("hz_rd_rw",     {31'd0, mem_rw},     32'd0);
    chk("hz_rd_addr",   mem_a,               32'h202);
    chk("hz_rd_wen",    {28'd0, mem_wen},    32'd0);
    man_dout = 32'h12345678;
    man_rdy  = 1'b1;
    #1;
    chk("hz_rd_ready", {31'd0, c_ready}, 32'd1);
    chk("hz_rd_data",  c_dout,           32'h12345678);
    nxt();
    c_strobe = 1'b0;
    #1;
    chk("hz_done_empty", {31'd0, wb_empty}, 32'd1);
    nxt();

    // read to an unrelated word overtakes the second queued store
    put_wr(32'h300, 32'h1, 4'b1111);
    nxt();
    put_wr(32'h304, 32'h2, 4'b1111);
    nxt();
    put_rd(32'h400);
    #1;
    chk("byp_wr_first", mem_a,            32'h300);
    chk("byp_stall",    {31'd0, c_ready}, 32'd0);
    man_rdy = 1'b1;
    nxt();
    nxt();
    #1;
    chk("byp_rd_rw",   {31'd0, mem_rw}, 32'd0);
    chk("byp_rd_addr", mem_a,           32'h400);
    man_dout = 32'hCAFEF00D;
    man_rdy  = 1'b1;
    #1;
    chk("byp_rd_ready", {31'd0, c_ready}, 32'd1);
    chk("byp_rd_data",  c_dout,           32'hCAFEF00D);
    nxt();
    c_strobe = 1'b0;
    drain_one(32'h304);
    #1;
    chk("byp_empty", {31'd0, wb_empty}, 32'd1);
    nxt();

    // reset in the middle of a memory write
    put_wr(32'h500, 32'h77, 4'b1111);
    nxt();
    put_wr(32'h504, 32'h88, 4'b1111);
    #1;
    chk("rstwr_in_wr", {31'd0, mem_strobe}, 32'd1);
    clrn = 1'b0;
    #1;
    chk("rstwr_strobe",   {31'd0, mem_strobe}, 32'd0);
    chk("rstwr_empty",    {31'd0, wb_empty},   32'd1);
    chk("rstwr_c_ready",  {31'd0, c_ready},    32'd0);
    chk("rstwr_mem_wen",  {28'd0, mem_wen},    32'd0);
    nxt();
    c_strobe = 1'b0;
    clrn = 1'b1;
    nxt();
    #1;
    chk("rstwr_discarded", {31'd0, mem_strobe}, 32'd0);
    chk("rstwr_still_empty", {31'd0, wb_empty}, 32'd1);
    nxt();

    // randomized traffic against a behavioural memory
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = $urandom;
      mem_model[i] = ref_mem[i];
    end
    auto_mem = 1'b1;
    lat = 0;
    for (int n = 0; n < 300; n++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        c_strobe = 1'b0;
        rand_cycle();
      end
      if ($urandom_range(0, 1) == 1)
        put_wr(32'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
      else
        put_rd(32'($urandom_range(0, 63)));
      done = 1'b0;
      waited = 0;
      while (!done && waited < 200) begin
        rand_cycle();
        waited++;
      end
      n_assert++;
      assert (done) else begin
        n_fail++;
        $error("FAIL req_timeout: request %0d to %h not completed after %0d cycles", n, c_a, waited);
      end
    end
    c_strobe = 1'b0;
    waited = 0;
    while (!(wb_empty && exp_q.size() == 0) && waited < 300) begin
      rand_cycle();
      waited++;
    end
    chk("final_empty", {31'd0, wb_empty}, 32'd1);
    chk("final_exp_q", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
